// File: rtl/vote_session_ctrl.sv
// Vote session front-end: arms one ballot per voter, debounces the four
// candidate buttons, emits one single-cycle vote pulse per ballot, then locks
// out until release plus a lockout period. In result mode the LEDs show the
// selected candidate's count.
// Optional build macro VOTE_TIMEOUT_EN: cancels an armed ballot after
// ARM_TIMEOUT_CYCLES without a press and raises a sticky timeout_flag.
module vote_session_ctrl #(
  parameter int DEBOUNCE_CYCLES    = 10,
  parameter int LOCKOUT_CYCLES     = 100,
  parameter int ARM_TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       arm,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  input  logic [7:0] candi1_vote_recvd,
  input  logic [7:0] candi2_vote_recvd,
  input  logic [7:0] candi3_vote_recvd,
  input  logic [7:0] candi4_vote_recvd,
  output logic       candi1_vote_valid,
  output logic       candi2_vote_valid,
  output logic       candi3_vote_valid,
  output logic       candi4_vote_valid,
  output logic       count_mode,
  output logic       ballot_ready,
  output logic       busy,
  output logic [7:0] led,
  output logic       timeout_flag
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [LW-1:0] L_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [LW-1:0] L_ONE  = LW'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  // Lowest-indexed pressed button (1..4), 0 when none is pressed.
  function automatic logic [2:0] prio_idx(input logic [3:0] b);
    logic [2:0] r;
    if (b[0])      r = 3'd1;
    else if (b[1]) r = 3'd2;
    else if (b[2]) r = 3'd3;
    else if (b[3]) r = 3'd4;
    else           r = 3'd0;
    return r;
  endfunction

  // One-hot candidate vector from index 1..4; index 0 maps to no candidate.
  function automatic logic [3:0] one_hot(input logic [2:0] c);
    logic [3:0] r;
    case (c)
      3'd1:    r = 4'b0001;
      3'd2:    r = 4'b0010;
      3'd3:    r = 4'b0100;
      3'd4:    r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  logic [2:0]    state, state_nx;
  logic [2:0]    cand, cand_nx;
  logic [2:0]    sel;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [LW-1:0] lcnt, lcnt_nx;
  logic [3:0]    btn;
  logic          any_btn;
  logic          cand_held;
  logic [7:0]    recvd_sel;

  assign btn       = {button4, button3, button2, button1};
  assign any_btn   = |btn;
  assign cand_held = |(btn & one_hot(cand));

`ifdef VOTE_TIMEOUT_EN
  localparam int TW = (ARM_TIMEOUT_CYCLES > 1) ? $clog2(ARM_TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ARM_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          to_set, to_clr;
`endif

  // Next-state and counter logic; result mode aborts any ballot in progress.
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    dcnt_nx  = dcnt;
    lcnt_nx  = lcnt;
`ifdef VOTE_TIMEOUT_EN
    tcnt_nx  = tcnt;
    to_set   = 1'b0;
    to_clr   = 1'b0;
`endif
    if (mode) begin
      state_nx = S_IDLE;
      dcnt_nx  = '0;
      lcnt_nx  = '0;
`ifdef VOTE_TIMEOUT_EN
      tcnt_nx  = '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (arm && !any_btn) begin
            state_nx = S_ARMED;
`ifdef VOTE_TIMEOUT_EN
            tcnt_nx  = '0;
            to_clr   = 1'b1;
`endif
          end else begin
            state_nx = S_IDLE;
          end
        end
        S_ARMED: begin
          if (any_btn) begin
            cand_nx  = prio_idx(btn);
            dcnt_nx  = '0;
            state_nx = S_HOLD;
          end else begin
`ifdef VOTE_TIMEOUT_EN
            if (tcnt >= T_LAST) begin
              state_nx = S_IDLE;
              to_set   = 1'b1;
            end else begin
              tcnt_nx  = tcnt + T_ONE;
            end
`else
            state_nx = S_ARMED;
`endif
          end
        end
        S_HOLD: begin
          if (cand_held) begin
            if (dcnt >= D_LAST) begin
              state_nx = S_COMMIT;
            end else begin
              dcnt_nx  = dcnt + D_ONE;
            end
          end else begin
            state_nx = S_ARMED;
            dcnt_nx  = '0;
`ifdef VOTE_TIMEOUT_EN
            tcnt_nx  = '0;
`endif
          end
        end
        S_COMMIT: begin
          state_nx = S_RELEASE;
        end
        S_RELEASE: begin
          if (!any_btn) begin
            state_nx = S_LOCKOUT;
            lcnt_nx  = '0;
          end else begin
            state_nx = S_RELEASE;
          end
        end
        S_LOCKOUT: begin
          if (lcnt >= L_LAST) begin
            state_nx = S_IDLE;
          end else begin
            lcnt_nx  = lcnt + L_ONE;
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // Count selected for display in result mode.
  always_comb begin
    case (sel)
      3'd1:    recvd_sel = candi1_vote_recvd;
      3'd2:    recvd_sel = candi2_vote_recvd;
      3'd3:    recvd_sel = candi3_vote_recvd;
      3'd4:    recvd_sel = candi4_vote_recvd;
      default: recvd_sel = 8'h00;
    endcase
  end

  // FSM state, latched candidate and debounce/lockout counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cand  <= 3'd0;
      dcnt  <= '0;
      lcnt  <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      dcnt  <= dcnt_nx;
      lcnt  <= lcnt_nx;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_mode        <= 1'b0;
      ballot_ready      <= 1'b0;
      busy              <= 1'b0;
      candi1_vote_valid <= 1'b0;
      candi2_vote_valid <= 1'b0;
      candi3_vote_valid <= 1'b0;
      candi4_vote_valid <= 1'b0;
    end else begin
      count_mode   <= mode;
      ballot_ready <= (state_nx == S_ARMED);
      busy         <= (state_nx == S_HOLD) || (state_nx == S_COMMIT) ||
                      (state_nx == S_RELEASE) || (state_nx == S_LOCKOUT);
      {candi4_vote_valid, candi3_vote_valid, candi2_vote_valid, candi1_vote_valid}
                   <= (state_nx == S_COMMIT) ? one_hot(cand_nx) : 4'b0000;
    end
  end

  // Result-mode selection and LED bus; sel survives mode changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel <= 3'd0;
      led <= 8'h00;
    end else begin
      if (mode && any_btn) begin
        sel <= prio_idx(btn);
      end else begin
        sel <= sel;
      end
      if (mode) begin
        led <= recvd_sel;
      end else if ((state_nx == S_COMMIT) || (state_nx == S_RELEASE) ||
                   (state_nx == S_LOCKOUT)) begin
        led <= {4'b0000, one_hot(cand_nx)};
      end else begin
        led <= 8'h00;
      end
    end
  end

`ifdef VOTE_TIMEOUT_EN
  // Armed-ballot timeout counter and sticky cancel flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      tcnt <= tcnt_nx;
      if (to_set) begin
        timeout_flag <= 1'b1;
      end else if (to_clr) begin
        timeout_flag <= 1'b0;
      end else begin
        timeout_flag <= timeout_flag;
      end
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed self-checking bench for vote_session_ctrl (DEBOUNCE 10,
// LOCKOUT 100, ARM_TIMEOUT 50).
module tb_vote_session_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode, arm;
  logic       button1, button2, button3, button4;
  logic [7:0] c1, c2, c3, c4;
  logic       v1, v2, v3, v4;
  logic       count_mode, ballot_ready, busy, timeout_flag;
  logic [7:0] led;

  int n_cmp = 0;
  int n_err = 0;
  int p1 = 0, p2 = 0, p3 = 0, p4 = 0;

  vote_session_ctrl #(
    .DEBOUNCE_CYCLES(10),
    .LOCKOUT_CYCLES(100),
    .ARM_TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .arm(arm),
    .button1(button1), .button2(button2), .button3(button3), .button4(button4),
    .candi1_vote_recvd(c1), .candi2_vote_recvd(c2),
    .candi3_vote_recvd(c3), .candi4_vote_recvd(c4),
    .candi1_vote_valid(v1), .candi2_vote_valid(v2),
    .candi3_vote_valid(v3), .candi4_vote_valid(v4),
    .count_mode(count_mode), .ballot_ready(ballot_ready), .busy(busy),
    .led(led), .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  // Count vote pulses away from the active edge.
  always @(negedge clock) begin
    if (v1) p1++;
    if (v2) p2++;
    if (v3) p3++;
    if (v4) p4++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; arm = 1'b0;
    button1 = 1'b0; button2 = 1'b0; button3 = 1'b0; button4 = 1'b0;
    c1 = 8'd7; c2 = 8'd0; c3 = 8'd255; c4 = 8'd3;
    step(2);
    check_eq("rst_led", led, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", ballot_ready, 1'b0);
    check_eq("rst_cmode", count_mode, 1'b0);
    check_eq("rst_valid", {v4, v3, v2, v1}, 4'b0000);
    reset = 1'b0;
    step(1);

    // Reset in the middle of HOLD.
    arm = 1'b1; step(1); arm = 1'b0;
    check_eq("arm_ready", ballot_ready, 1'b1);
    button2 = 1'b1; step(1);
    check_eq("hold_busy", busy, 1'b1);
    check_eq("hold_ready", ballot_ready, 1'b0);
    step(4);
    reset = 1'b1; #1;
    check_eq("amid_busy", busy, 1'b0);
    check_eq("amid_ready", ballot_ready, 1'b0);
    check_eq("amid_valid", {v4, v3, v2, v1}, 4'b0000);
    step(2);
    reset = 1'b0; button2 = 1'b0;
    step(15);
    check_eq("amid_nopulse", p2, 0);
    check_eq("amid_idle", busy, 1'b0);

    // Normal ballot on button3, 11-cycle latency.
    arm = 1'b1; step(1); arm = 1'b0;
    check_eq("b3_armed", ballot_ready, 1'b1);
    button3 = 1'b1; step(1);
    check_eq("b3_ready_drop", ballot_ready, 1'b0);
    step(9);
    check_eq("b3_early", p3, 0);
    step(1);
    check_eq("b3_pulse", {v4, v3, v2, v1}, 4'b0100);
    check_eq("b3_led_commit", led, 8'h04);
    step(1);
    check_eq("b3_pulse_end", v3, 1'b0);
    check_eq("b3_count", p3, 1);
    step(8);
    button3 = 1'b0;
    check_eq("b3_led_held", led, 8'h04);
    step(1);
    // Lockout: a press and an arm request must both be ignored.
    step(40);
    check_eq("lk_led", led, 8'h04);
    button1 = 1'b1; arm = 1'b1; step(5);
    button1 = 1'b0; step(5);
    arm = 1'b0; step(49);
    check_eq("lk_busy_last", busy, 1'b1);
    check_eq("lk_led_last", led, 8'h04);
    check_eq("lk_no_rearm", ballot_ready, 1'b0);
    step(1);
    check_eq("lk_done_busy", busy, 1'b0);
    check_eq("lk_done_led", led, 8'h00);
    check_eq("lk_no_b1", p1, 0);
    check_eq("lk_b3_once", p3, 1);
    arm = 1'b1; step(1); arm = 1'b0;
    check_eq("rearm", ballot_ready, 1'b1);

    // Button1 glitch, then button4 with 2/3 pressed during its HOLD.
    button1 = 1'b1; step(4);
    button1 = 1'b0; step(1);
    check_eq("glitch_back", ballot_ready, 1'b1);
    check_eq("glitch_busy", busy, 1'b0);
    button4 = 1'b1; step(1);
    button2 = 1'b1; button3 = 1'b1; step(3);
    button2 = 1'b0; button3 = 1'b0; step(6);
    check_eq("b4_early", p4, 0);
    step(1);
    check_eq("b4_pulse", {v4, v3, v2, v1}, 4'b1000);
    check_eq("b4_led", led, 8'h08);
    step(4);
    button4 = 1'b0;
    check_eq("b4_once", p4, 1);
    check_eq("b4_no_b1", p1, 0);
    check_eq("b4_no_b2", p2, 0);
    check_eq("b4_no_b3", p3, 1);
    step(101);
    check_eq("b4_idle", busy, 1'b0);

    // Result mode display.
    mode = 1'b1; step(1);
    check_eq("res_cmode", count_mode, 1'b1);
    check_eq("res_nosel", led, 8'h00);
    button3 = 1'b1; step(1);
    check_eq("res_sel_lag", led, 8'h00);
    step(1);
    check_eq("res_led3", led, 8'hFF);
    button3 = 1'b0; step(2);
    check_eq("res_keep3", led, 8'hFF);
    button4 = 1'b1; step(2);
    check_eq("res_led4", led, 8'h03);
    button4 = 1'b0;

    // Ballot aborted by result mode.
    mode = 1'b0; step(1);
    check_eq("vote_cmode", count_mode, 1'b0);
    check_eq("vote_led", led, 8'h00);
    arm = 1'b1; step(1); arm = 1'b0;
    button2 = 1'b1; step(3);
    check_eq("abort_hold", busy, 1'b1);
    mode = 1'b1; step(1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_ready", ballot_ready, 1'b0);
    check_eq("abort_led_old", led, 8'h03);
    step(12);
    check_eq("abort_led_new", led, 8'h00);
    check_eq("abort_no_b2", p2, 0);
    button2 = 1'b0; mode = 1'b0; step(2);
    check_eq("abort_lost", ballot_ready, 1'b0);
    check_eq("abort_idle", busy, 1'b0);

    // Armed-ballot timeout (or indefinite wait without the feature).
    arm = 1'b1; step(1); arm = 1'b0;
    check_eq("to_armed", ballot_ready, 1'b1);
    step(49);
    check_eq("to_pre_ready", ballot_ready, 1'b1);
    check_eq("to_pre_flag", timeout_flag, 1'b0);
    step(1);
`ifdef VOTE_TIMEOUT_EN
    check_eq("to_ready", ballot_ready, 1'b0);
    check_eq("to_flag", timeout_flag, 1'b1);
`else
    check_eq("to_ready", ballot_ready, 1'b1);
    check_eq("to_flag", timeout_flag, 1'b0);
`endif
    arm = 1'b1; step(1); arm = 1'b0;
    check_eq("to_rearm", ballot_ready, 1'b1);
    check_eq("to_flag_clr", timeout_flag, 1'b0);

    check_eq("final_p1", p1, 0);
    check_eq("final_p2", p2, 0);
    check_eq("final_p3", p3, 1);
    check_eq("final_p4", p4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Front-end controller for the four-candidate vote counter.
- Arms one ballot per voter at the officer's command, debounces the candidate buttons, and issues exactly one single-cycle candiN_vote_valid pulse per ballot.
- Locks out further votes until the buttons are released and a lockout period has elapsed.
- In result mode it drives the vote counter's mode input, ignores votes, and multiplexes the selected candidate's count onto the LEDs.

Parameters:
DEBOUNCE_CYCLES, 10, consecutive cycles a button must be held stable before the vote commits (min 1)
LOCKOUT_CYCLES, 100, cycles after release before the next ballot may be armed (min 1)
ARM_TIMEOUT_CYCLES, 1000, max cycles in ARMED before the ballot is cancelled (used only with VOTE_TIMEOUT_EN)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
mode  input  1  0 = voting, 1 = result display; synchronous level
arm  input  1  officer ballot-arm request, sampled each cycle
button1..button4  input  1 each  candidate buttons, already synchronised, active-high
candi1_vote_recvd..candi4_vote_recvd  input  8 each  current counts from the vote counter
candi1_vote_valid..candi4_vote_valid  output  1 each  single-cycle vote pulses to the vote counter
count_mode  output  1  registered copy of mode, feeds the vote counter's mode input
ballot_ready  output  1  high while in ARMED
busy  output  1  high in HOLD, COMMIT, RELEASE, LOCKOUT
led  output  8  display bus
timeout_flag  output  1  sticky cancelled-ballot indicator (VOTE_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, active-high):
  - All outputs 0; state = IDLE.
  - Debounce and lockout counters 0; sel = 0; cand = 0.
- count_mode <= mode every cycle (1-cycle latency).
- FSM, evaluated only when mode = 0:
  - IDLE: arm = 1 and no button pressed -> ARMED. arm while any button is pressed is ignored.
  - ARMED:
    - ballot_ready = 1.
    - First cycle with any button high: latch cand = lowest-indexed pressed button (priority 1>2>3>4), clear debounce counter, -> HOLD.
  - HOLD:
    - While button[cand] = 1, the counter increments.
    - On reaching DEBOUNCE_CYCLES-1 -> COMMIT.
    - button[cand] = 0 before that -> back to ARMED (counter cleared, no vote).
    - Other buttons are ignored.
  - COMMIT:
    - Exactly one cycle; candi[cand]_vote_valid = 1, all other valid outputs 0.
    - -> RELEASE.
  - RELEASE: wait until all four buttons are 0 -> LOCKOUT (counter cleared).
  - LOCKOUT: count LOCKOUT_CYCLES cycles -> IDLE. arm is ignored throughout.
- At most one valid pulse per ARMED->COMMIT pass; a held button never produces a second pulse.
- Pressed-button total latency: ARMED detect -> HOLD (1 cycle) -> DEBOUNCE_CYCLES in HOLD -> pulse asserted in COMMIT.
  - DEBOUNCE_CYCLES = 10: pulse appears 11 cycles after the first sampled press.
- mode = 1 (any state, including mid-ballot):
  - FSM forced to IDLE next cycle; no valid pulse issued.
  - An aborted ballot is lost and must be re-armed.
  - Counters are cleared.
- led:
  - Voting mode: led[3:0] = one-hot of cand during COMMIT, RELEASE, LOCKOUT; led[7:4] = 0; led = 0 in IDLE, ARMED, HOLD.
  - Result mode:
    - Any button high -> sel <= lowest-indexed pressed (priority as above), registered.
    - led = candi[sel]_vote_recvd, registered.
    - sel = 0 (no selection yet) -> led = 0.
    - sel is retained across mode changes; it is cleared only by reset.
- Counter widths: $clog2 of the respective parameter, minimum 1. Counters saturate and never wrap.
- The vote counter's 8-bit wrap is not this block's concern.

Optional Feature:
- Macro VOTE_TIMEOUT_EN.
- Defined:
  - ARMED counts cycles; on reaching ARM_TIMEOUT_CYCLES without a press -> IDLE.
  - timeout_flag set; it is cleared on the next arm = 1 accepted in IDLE.
  - The counter clears on ARMED entry, including re-entry from HOLD.
- Undefined:
  - ARMED waits indefinitely.
  - timeout_flag constant 0; no timeout counter is synthesised.

Test Plan:
- Reset mid-HOLD (button2 held 5 cycles) -> all outputs 0 immediately; state IDLE; no candi2_vote_valid pulse.
- mode=0, arm 1 cycle, button3 held 20 cycles -> single candi3_vote_valid pulse, 11 cycles after press; ballot_ready drops on press; led = 8'h04 until lockout ends (100 cycles after release).
- Button1 glitch 4 cycles, then button4 held 15 cycles -> no candi1 pulse; one candi4 pulse; button2/3 pressed during HOLD of button4 are ignored.
- Second press during LOCKOUT, and arm during LOCKOUT -> no pulse, no re-arm; arm accepted in IDLE after lockout.
- mode=1 with counts 7/0/255/3, press button3 -> led = 8'hFF one cycle after sel updates; press button4 -> led = 8'h03; no valid pulses throughout.
- VOTE_TIMEOUT_EN, ARM_TIMEOUT_CYCLES=50: arm, no press -> return to IDLE after 50 cycles; timeout_flag = 1; next arm clears it.
